// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO controller: wrap-bit pointer arithmetic and capacity.
// Pointers travel through these functions zero-extended to ptr_t, so one set serves any DEPTH.
package fifo_pkg;

    typedef logic [31:0] ptr_t;

    function automatic ptr_t ptr_mask(input int unsigned bits);
        return (ptr_t'(1) << bits) - ptr_t'(1);
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t ptr, input int unsigned depth);
        return (ptr + ptr_t'(1)) & ptr_mask(depth + 1);
    endfunction

    function automatic logic ptrs_empty(input ptr_t wr, input ptr_t rd, input int unsigned depth);
        return ((wr ^ rd) & ptr_mask(depth + 1)) == '0;
    endfunction

    // Full means same slot, opposite lap: low bits match and the wrap bits differ.
    function automatic logic ptrs_full(input ptr_t wr, input ptr_t rd, input int unsigned depth);
        ptr_t diff;
        diff = wr ^ rd;
        return ((diff & ptr_mask(depth)) == '0) && (((diff >> depth) & ptr_t'(1)) != '0);
    endfunction

    // Words held at most: every memory slot plus the output register.
    function automatic int unsigned fifo_capacity(input int unsigned depth);
        return (32'd1 << depth) + 32'd1;
    endfunction

endpackage

// File: rtl/mem_param.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are never reset; the controller only reads slots it has written.
module mem_param #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// Valid/ready FIFO built around mem_param with a registered output stage.
// The output register prefetches from memory, so level counts memory words plus that register.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 1024,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 2**DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH+1:0] level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf_err
);

    localparam int PW = DEPTH + 1;
    localparam int LW = DEPTH + 2;
    localparam int unsigned CAPACITY = fifo_capacity(DEPTH);
    localparam logic [LW-1:0] CAP_L    = LW'(CAPACITY);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

    logic [DEPTH:0]   wr_ptr;
    logic [DEPTH:0]   rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             mem_full;
    logic             mem_empty;
    logic             push;
    logic             pop;
    logic             load;
    logic             mem_we;
    logic [LW-1:0]    level_next;

    assign mem_full  = ptrs_full(ptr_t'(wr_ptr), ptr_t'(rd_ptr), DEPTH);
    assign mem_empty = ptrs_empty(ptr_t'(wr_ptr), ptr_t'(rd_ptr), DEPTH);

    // Flush suppresses every event; the write strobe also dies the moment rst_n falls.
    assign in_ready = !mem_full;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;
    assign load     = !mem_empty && (!out_valid || out_ready) && !flush;
    assign mem_we   = push && rst_n;

    mem_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[DEPTH-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[DEPTH-1:0]),
        .rdata (rdata)
    );

    // A move from memory into the output register leaves the total unchanged.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            level     <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= PW'(ptr_inc(ptr_t'(wr_ptr), DEPTH));
            end
            if (flush) begin
                rd_ptr    <= wr_ptr;
                out_valid <= 1'b0;
                ovf_err   <= 1'b0;
            end else begin
                if (load) begin
                    out_data  <= rdata;
                    out_valid <= 1'b1;
                    rd_ptr    <= PW'(ptr_inc(ptr_t'(rd_ptr), DEPTH));
                end else if (pop) begin
                    out_valid <= 1'b0;
                end
                if (in_valid && !in_ready) begin
                    ovf_err <= 1'b1;
                end
            end
            level <= level_next;
        end
    end

    assign almost_full  = (level >= AFULL_L);
    assign almost_empty = (level <= AEMPTY_L);

    level_bound: assert property (@(posedge clk) disable iff (!rst_n) level <= CAP_L);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random traffic against a queue model.
// A second, full-size instance gets a short smoke run.
module tb_fifo_ctrl;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int AF   = 4;
    localparam int AE   = 1;
    localparam int MEMW = 1 << D;
    localparam int BW   = 1024;
    localparam int BD   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           flush, in_valid, out_ready, in_ready, out_valid;
    logic [W-1:0]   in_data, out_data;
    logic [D+1:0]   level;
    logic           almost_full, almost_empty, ovf_err;

    logic           b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [BW-1:0]  b_in_data, b_out_data;
    logic [BD+1:0]  b_level;
    logic           b_almost_full, b_almost_empty, b_ovf_err;

    fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .ovf_err(ovf_err)
    );

    fifo_ctrl #(.WIDTH(BW), .DEPTH(BD)) u_wide (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .level(b_level), .almost_full(b_almost_full), .almost_empty(b_almost_empty),
        .ovf_err(b_ovf_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: everything held, in order, with the head visible once it has been loaded.
    logic [W-1:0] mq[$];
    bit           m_ov;
    bit           m_ovf;
    logic [W-1:0] m_out;

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_ovf = 1'b0;
        m_out = '0;
    endtask

    task automatic applyStimulus(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        int memcnt;
        bit rdy, push, pop, load;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        memcnt = mq.size() - int'(m_ov);
        rdy    = memcnt < MEMW;
        if (fl) begin
            mq.delete();
            m_ov  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            push = iv && rdy;
            pop  = m_ov && ordy;
            load = (memcnt > 0) && (!m_ov || ordy);
            if (iv && !rdy) m_ovf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (load) begin
                m_out = mq[0];
                m_ov  = 1'b1;
            end else if (pop) begin
                m_ov = 1'b0;
            end
            if (push) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_aempty got=%0b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_afull got=%0b exp=0", almost_full); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%0b exp=0", ovf_err); end

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        checks++; if (level !== 4'd3) begin failures++; $display("[TB] FAIL premid_level got=%0d exp=3", level); end

        // Asynchronous reset taken between edges must act before the next edge.
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL midreset_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_edge1_valid got=%0b exp=0", out_valid); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            failures++; $display("[TB] FAIL lat_edge2 got valid=%0b data=%0h exp valid=1 data=a5", out_valid, out_data);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checks++; if (level !== 4'(i)) begin failures++; $display("[TB] FAIL fill_level got=%0d exp=%0d", level, i); end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_in_ready got=%0b exp=0", in_ready); end
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("[TB] FAIL fill_ovf got=%0b exp=1", ovf_err); end
        checks++; if (level !== 4'd5) begin failures++; $display("[TB] FAIL fill_ovf_level got=%0d exp=5", level); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                failures++; $display("[TB] FAIL drain_word got valid=%0b data=%0h exp valid=1 data=%0h", out_valid, out_data, i);
            end
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_end_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL drain_end_level got=%0d exp=0", level); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        bit seen = 1'b0;
        for (int c = 0; c < 40 && got < 20; c++) begin
            if (sent < 20) begin
                applyStimulus(1'b1, 8'(8'h10 + sent), 1'b1, 1'b0);
                sent++;
            end else begin
                applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            end
            if (seen) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_gap got valid=%0b exp=1 at word %0d", out_valid, got); end
            end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 8'(8'h10 + got)) begin
                    failures++; $display("[TB] FAIL wrap_order got=%0h exp=%0h", out_data, 8'(8'h10 + got));
                end
                got++;
                seen = 1'b1;
            end
        end
        checks++; if (got != 20) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=20", got); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
            failures++; $display("[TB] FAIL wrap_end got valid=%0b level=%0d exp valid=0 level=0", out_valid, level);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        checks++; if (level !== 4'd4) begin failures++; $display("[TB] FAIL preflush_level got=%0d exp=4", level); end
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("[TB] FAIL preflush_ovf_sticky got=%0b exp=1", ovf_err); end
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL flush_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid got=%0b exp=0", out_valid); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("[TB] FAIL flush_ovf got=%0b exp=0", ovf_err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got=%0b exp=1", in_ready); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
            failures++; $display("[TB] FAIL flush_nowrite got valid=%0b level=%0d exp valid=0 level=0", out_valid, level);
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            failures++; $display("[TB] FAIL postflush_word got valid=%0b data=%0h exp valid=1 data=55", out_valid, out_data);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_thresholds();
        checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            failures++; $display("[TB] FAIL thr_lvl0 got af=%0b ae=%0b exp af=0 ae=1", almost_full, almost_empty);
        end
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
            checks++; if (level !== 4'(k) || almost_full !== (k >= AF) || almost_empty !== (k <= AE)) begin
                failures++; $display("[TB] FAIL thr_up got lvl=%0d af=%0b ae=%0b exp lvl=%0d af=%0b ae=%0b",
                                     level, almost_full, almost_empty, k, k >= AF, k <= AE);
            end
        end
        for (int k = 4; k >= 0; k--) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (level !== 4'(k) || almost_full !== (k >= AF) || almost_empty !== (k <= AE)) begin
                failures++; $display("[TB] FAIL thr_down got lvl=%0d af=%0b ae=%0b exp lvl=%0d af=%0b ae=%0b",
                                     level, almost_full, almost_empty, k, k >= AF, k <= AE);
            end
        end
    endtask

    task automatic test_random();
        bit iv, ordy, fl;
        int sz;
        for (int i = 0; i < 400; i++) begin
            // Phases bias traffic toward filling, balanced flow, then draining.
            iv   = (i < 130) ? ($urandom_range(0, 3) != 0) : (i < 270) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
            ordy = (i < 130) ? ($urandom_range(0, 3) == 0) : (i < 270) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            applyStimulus(iv, 8'($urandom), ordy, fl);
            sz = mq.size();
            checks++; if (level !== 4'(sz)) begin failures++; $display("[TB] FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, sz); end
            checks++; if (out_valid !== m_ov) begin failures++; $display("[TB] FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, m_ov); end
            checks++; if (out_data !== m_out) begin failures++; $display("[TB] FAIL rnd_out_data cyc=%0d got=%0h exp=%0h", i, out_data, m_out); end
            checks++; if (in_ready !== ((sz - int'(m_ov)) < MEMW)) begin
                failures++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, (sz - int'(m_ov)) < MEMW);
            end
            checks++; if (ovf_err !== m_ovf) begin failures++; $display("[TB] FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, ovf_err, m_ovf); end
            checks++; if (almost_full !== (sz >= AF) || almost_empty !== (sz <= AE)) begin
                failures++; $display("[TB] FAIL rnd_flags cyc=%0d got af=%0b ae=%0b exp af=%0b ae=%0b", i, almost_full, almost_empty, sz >= AF, sz <= AE);
            end
        end
    endtask

    task automatic wide_step(input bit iv, input logic [BW-1:0] d, input bit ordy);
        b_in_valid  = iv;
        b_in_data   = d;
        b_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_smoke_wide();
        logic [BW-1:0] ws [3];
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < BW / 32; k++) ws[n][k*32 +: 32] = $urandom;
        checks++; if (b_in_ready !== 1'b1 || b_level !== 10'd0) begin
            failures++; $display("[TB] FAIL wide_idle got rdy=%0b lvl=%0d exp rdy=1 lvl=0", b_in_ready, b_level);
        end
        for (int n = 0; n < 3; n++) wide_step(1'b1, ws[n], 1'b0);
        checks++; if (b_level !== 10'd3 || b_almost_empty !== 1'b0 || b_almost_full !== 1'b0) begin
            failures++; $display("[TB] FAIL wide_level got lvl=%0d ae=%0b af=%0b exp lvl=3 ae=0 af=0", b_level, b_almost_empty, b_almost_full);
        end
        for (int n = 0; n < 3; n++) begin
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== ws[n]) begin
                failures++; $display("[TB] FAIL wide_word%0d got valid=%0b low=%0h exp valid=1 low=%0h", n, b_out_valid, b_out_data[63:0], ws[n][63:0]);
            end
            wide_step(1'b0, '0, 1'b1);
        end
        checks++; if (b_out_valid !== 1'b0 || b_level !== 10'd0) begin
            failures++; $display("[TB] FAIL wide_end got valid=%0b lvl=%0d exp valid=0 lvl=0", b_out_valid, b_level);
        end
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] starting fifo_ctrl bench");
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_thresholds();
        test_random();
        test_smoke_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
